// File: rtl/seq_sub_64bit_pkg.sv
// Shared definitions for the sequential chunked subtractor.
//   state_e      : FSM states (IDLE / RUN / DONE)
//   DEF_WIDTH    : default operand width
//   DEF_CHUNK    : default bits handled per clock
//   num_chunks() : cycles per operation (WIDTH / CHUNK)
//   idx_width()  : chunk index register width (clog2 N, at least 1)
package seq_sub_64bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 8;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_sub_64bit_borrow_sub_chunk.sv
// borrow_sub_chunk: combinational CHUNK-bit ripple-borrow subtractor.
//   a, b : chunk operands
//   bin  : borrow into bit 0
//   d    : a - b - bin (mod 2^CHUNK)
//   bout : 1 iff unsigned a < b + bin
// Built from per-bit full subtractors so no internal value exceeds one bit.
module seq_sub_64bit_borrow_sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] brw;

    assign brw[0] = bin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign d[i]       = a[i] ^ b[i] ^ brw[i];
        // Borrow when a=0,b=1, or a==b with an incoming borrow.
        assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end

    assign bout = brw[CHUNK];

endmodule

// File: rtl/seq_sub_64bit.sv
// seq_sub_64bit: multi-cycle subtractor, diff = a - b - bin over WIDTH bits,
// one CHUNK-wide slice per clock with the borrow carried in a register.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, bin sampled on accept)
//   out_valid/out_ready : result handshake (diff, bout, ovf, zero held until taken)
//   busy                : operation in RUN or waiting in DONE
module seq_sub_64bit
    import seq_sub_64bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int N    = num_chunks(WIDTH, CHUNK);
    localparam int IDXW = idx_width(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              borrow_q, borrow_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_d;
    logic              chunk_bout;

    // Single subtractor, time-multiplexed over the operand slices by idx.
    assign chunk_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

    seq_sub_64bit_borrow_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .bin  (borrow_q),
        .d    (chunk_d),
        .bout (chunk_bout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d[int'(idx_q) * CHUNK +: CHUNK] = chunk_d;
                borrow_d = chunk_bout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // The last slice carries the MSB, so the flags see the final diff.
                    bout_d  = chunk_bout;
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (chunk_d[CHUNK-1] != a_q[WIDTH-1]);
                    zero_d  = (diff_d == '0);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
